// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed seven-segment scanner with double-buffered, frame-synchronous display updates.
// Define SEVENSEG_LZB_EN to blank leading zero digits (digit 0 is always shown).
module sevenseg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dots_in,
  input  logic                    load,
  output logic [6:0]              segment,
  output logic [NUM_DIGITS-1:0]   seg_enable_num,
  output logic                    dot,
  output logic                    frame_start,
  output logic                    pending
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        r_prescale;
  logic [IDX_W-1:0]        r_digitIdx;
  logic [4*NUM_DIGITS-1:0] r_pendData;
  logic [NUM_DIGITS-1:0]   r_pendDots;
  logic                    r_pending;
  logic [4*NUM_DIGITS-1:0] r_dispData;
  logic [NUM_DIGITS-1:0]   r_dispDots;
  logic                    r_frameStart;

  logic                    w_tick;
  logic                    w_frameBoundary;
  logic                    w_inBlank;
  logic [3:0]              w_selNibble;
  logic [6:0]              w_segNext;
  logic [NUM_DIGITS-1:0]   w_enableSel;

  function automatic logic [6:0] decodeHex(input logic [3:0] nibble);
    case (nibble)
      4'h0:    return 7'h01;
      4'h1:    return 7'h4F;
      4'h2:    return 7'h12;
      4'h3:    return 7'h06;
      4'h4:    return 7'h4C;
      4'h5:    return 7'h24;
      4'h6:    return 7'h20;
      4'h7:    return 7'h0F;
      4'h8:    return 7'h00;
      4'h9:    return 7'h04;
      4'hA:    return 7'h08;
      4'hB:    return 7'h60;
      4'hC:    return 7'h31;
      4'hD:    return 7'h42;
      4'hE:    return 7'h30;
      default: return 7'h38;
    endcase
  endfunction

  assign w_tick          = (r_prescale == CNT_LAST);
  assign w_frameBoundary = w_tick && (r_digitIdx == IDX_LAST);
  assign w_inBlank       = (r_prescale < CNT_BLANK);
  assign w_selNibble     = r_dispData[4*int'(r_digitIdx) +: 4];

  always_comb begin
    w_enableSel             = '1;
    w_enableSel[r_digitIdx] = 1'b0;
  end

`ifdef SEVENSEG_LZB_EN
  logic [NUM_DIGITS-1:0] w_upperZero;

  // w_upperZero[k] is set when nibble k and every nibble above it are zero.
  always_comb begin
    logic w_allZeroAbove;
    w_allZeroAbove = 1'b1;
    w_upperZero    = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_allZeroAbove = w_allZeroAbove & (r_dispData[4*k +: 4] == 4'h0);
      w_upperZero[k] = w_allZeroAbove;
    end
  end

  assign w_segNext = ((r_digitIdx != '0) && w_upperZero[r_digitIdx]) ? 7'h7F
                                                                      : decodeHex(w_selNibble);
`else
  assign w_segNext = decodeHex(w_selNibble);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prescale <= '0;
      r_digitIdx <= '0;
    end else begin
      r_prescale <= w_tick ? '0 : r_prescale + CNT_W'(1);
      if (w_tick) begin
        r_digitIdx <= (r_digitIdx == IDX_LAST) ? '0 : r_digitIdx + IDX_W'(1);
      end
    end
  end

  // The display copy only moves at a frame boundary, so a frame never mixes old and new values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pendData   <= '0;
      r_pendDots   <= '0;
      r_pending    <= 1'b0;
      r_dispData   <= '0;
      r_dispDots   <= '0;
      r_frameStart <= 1'b0;
    end else begin
      r_frameStart <= w_frameBoundary;
      if (w_frameBoundary && r_pending) begin
        r_dispData <= r_pendData;
        r_dispDots <= r_pendDots;
      end
      if (load) begin
        r_pendData <= data_in;
        r_pendDots <= dots_in;
        r_pending  <= 1'b1;
      end else if (w_frameBoundary) begin
        r_pending  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      segment        <= 7'h7F;
      seg_enable_num <= '1;
      dot            <= 1'b1;
    end else begin
      segment        <= w_segNext;
      seg_enable_num <= w_inBlank ? '1 : w_enableSel;
      dot            <= ~r_dispDots[r_digitIdx];
    end
  end

  assign frame_start = r_frameStart;
  assign pending     = r_pending;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Scoreboard bench for sevenseg_scan_ctrl (4 digits, 4 clocks per slot, 1 blank cycle).
// Honours SEVENSEG_LZB_EN in its expected-segment model.
module tb_sevenseg_scan_ctrl;

  localparam int ND = 4;
  localparam int SLOT = 4;
  localparam int FRAME = ND * SLOT;
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data_in = '0;
  logic [3:0]  dots_in = '0;
  logic        load = 1'b0;
  logic [6:0]  segment;
  logic [3:0]  seg_enable_num;
  logic        dot;
  logic        frame_start;
  logic        pending;

  int vectorCount = 0;
  int missCount = 0;

  // Reference model state: {dots, data} for pending and displayed values.
  int          edgeCount = 0;
  logic [19:0] mPend = '0;
  logic        mPendValid = 1'b0;
  logic [19:0] mDisp = '0;
  logic        expFrameStart = 1'b0;
  logic [19:0] expQ [$];

  logic        rstSeen = 1'b0;
  logic [19:0] curVal = '0;
  int          slotPos = 0;

  sevenseg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .CLK_DIV     (SLOT),
    .BLANK_CYCLES(1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .dots_in       (dots_in),
    .load          (load),
    .segment       (segment),
    .seg_enable_num(seg_enable_num),
    .dot           (dot),
    .frame_start   (frame_start),
    .pending       (pending)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  function automatic logic [6:0] expSeg(input logic [15:0] val, input int digit);
    logic [15:0] shifted;
    shifted = val >> (4 * digit);
`ifdef SEVENSEG_LZB_EN
    if (digit != 0 && shifted == 16'h0) return 7'h7F;
`endif
    return SEG_TABLE[shifted[3:0]];
  endfunction

  // Model: every FRAME clocks after reset the last pending load becomes the displayed frame.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        edgeCount     = 0;
        mPend         = '0;
        mPendValid    = 1'b0;
        mDisp         = '0;
        expFrameStart = 1'b0;
        expQ.delete();
      end else begin
        edgeCount++;
        expFrameStart = (edgeCount % FRAME == 0);
        if (expFrameStart && mPendValid) mDisp = mPend;
        if (load) begin
          mPend      = {dots_in, data_in};
          mPendValid = 1'b1;
        end else if (expFrameStart) begin
          mPendValid = 1'b0;
        end
        if (expFrameStart) expQ.push_back(mDisp);
      end
    end
  end

  always @(posedge clk) rstSeen <= rst;

  // Monitor: walks the current expected frame slot by slot, taking a new frame on each frame_start.
  always @(negedge clk) begin
    int          digit;
    logic [3:0]  expEn;
    logic        expDot;
    if (rstSeen) begin
      checkOutput("rstSegment", segment, 7'h7F);
      checkOutput("rstEnable", seg_enable_num, 4'hF);
      checkOutput("rstDot", dot, 1'b1);
      checkOutput("rstPending", pending, 1'b0);
      checkOutput("rstFrameStart", frame_start, 1'b0);
      curVal  = '0;
      slotPos = 0;
    end else begin
      checkOutput("frameStart", frame_start, expFrameStart);
      checkOutput("pending", pending, mPendValid);
      if (slotPos >= FRAME) begin
        checkOutput("frameLength", slotPos, FRAME - 1);
        slotPos = 0;
      end
      digit  = slotPos / SLOT;
      expEn  = (slotPos % SLOT == 0) ? 4'hF : ~(4'b0001 << digit);
      expDot = ~curVal[16 + digit];
      checkOutput("segment", segment, expSeg(curVal[15:0], digit));
      checkOutput("enable", seg_enable_num, expEn);
      checkOutput("dot", dot, expDot);
      slotPos++;
      if (frame_start) begin
        vectorCount++;
        if (expQ.size() == 0) begin
          missCount++;
          $display("[TB] FAIL frameQueue at %0t: got frame_start, expected no frame", $time);
        end else begin
          curVal = expQ.pop_front();
        end
        slotPos = 0;
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] data, input logic [3:0] dots, input logic doLoad);
    data_in = data;
    dots_in = dots;
    load    = doLoad;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  // Idles until the next edge will be edge number target+1 within the frame.
  task automatic waitForSlot(input int target);
    int guard = 0;
    while ((edgeCount % FRAME) != target && guard < 4 * FRAME) begin
      applyStimulus(16'($urandom), 4'($urandom), 1'b0);
      guard++;
    end
    if ((edgeCount % FRAME) != target) begin
      checkOutput("slotWait", edgeCount % FRAME, target);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(16'h0, 4'h0, 1'b0);
    applyStimulus(16'h0, 4'h0, 1'b0);
    applyStimulus(16'hFFFF, 4'hF, 1'b1);
    rst = 1'b0;
    repeat (2 * FRAME) applyStimulus(16'($urandom), 4'($urandom), 1'b0);

    waitForSlot(5);
    applyStimulus(16'h12AF, 4'b0100, 1'b1);
    repeat (2 * FRAME) applyStimulus(16'($urandom), 4'($urandom), 1'b0);

    waitForSlot(3);
    applyStimulus(16'h1111, 4'b0001, 1'b1);
    applyStimulus(16'h2222, 4'b0010, 1'b1);
    repeat (2 * FRAME) applyStimulus(16'($urandom), 4'($urandom), 1'b0);

    waitForSlot(4);
    applyStimulus(16'h4444, 4'b1000, 1'b1);
    waitForSlot(15);
    applyStimulus(16'h3333, 4'b0011, 1'b1);
    repeat (2 * FRAME + 4) applyStimulus(16'($urandom), 4'($urandom), 1'b0);

    waitForSlot(2);
    applyStimulus(16'h0050, 4'b0000, 1'b1);
    repeat (2 * FRAME) applyStimulus(16'($urandom), 4'($urandom), 1'b0);
    waitForSlot(7);
    applyStimulus(16'h0000, 4'b0001, 1'b1);
    repeat (2 * FRAME) applyStimulus(16'($urandom), 4'($urandom), 1'b0);

    waitForSlot(2);
    applyStimulus(16'h5A5A, 4'b1111, 1'b1);
    repeat (FRAME) applyStimulus(16'($urandom), 4'($urandom), 1'b0);
    waitForSlot(2);
    applyStimulus(16'h9876, 4'b0101, 1'b1);
    waitForSlot(9);
    rst = 1'b1;
    applyStimulus(16'hBEEF, 4'hF, 1'b1);
    rst = 1'b0;
    repeat (2 * FRAME) applyStimulus(16'($urandom), 4'($urandom), 1'b0);

    for (int i = 0; i < 300; i++) begin
      applyStimulus(16'($urandom), 4'($urandom), ($urandom_range(0, 5) == 0));
    end
    repeat (3 * FRAME) applyStimulus(16'($urandom), 4'($urandom), 1'b0);

    @(negedge clk);
    checkOutput("queueDrain", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
